// File: rtl/laser_controller.sv
// Laser bolt engine: SLOTS bolts per cannon (T fires up, B fires down), tick-driven motion and cooldown.
// Optional build macro LASER_AUTOFIRE_EN: a held fire button relaunches on every tick once the cooldown is clear.
module laser_controller #(
  parameter int SLOTS     = 3,
  parameter int LASER_W   = 4,
  parameter int LASER_LEN = 24,
  parameter int SPEED     = 2,
  parameter int COOLDOWN  = 20,
  parameter int X_LEFT    = 462,
  parameter int TOP_Y     = 187,
  parameter int BOT_Y     = 365,
  parameter int V_TOP     = 35,
  parameter int V_BOT     = 515
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       fire_top,
  input  logic       fire_bot,
  input  logic       bright,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       laser_fill,
  output logic [3:0] top_count,
  output logic [3:0] bot_count,
  output logic       top_full,
  output logic       bot_full
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic [9:0]      T_INIT  = 10'(TOP_Y - LASER_LEN);
  localparam logic [9:0]      B_INIT  = 10'(BOT_Y);
  localparam logic [9:0]      T_LIMIT = 10'(V_TOP + SPEED);
  localparam logic [10:0]     B_LIMIT = 11'(V_BOT);
  localparam logic [10:0]     B_REACH = 11'(LASER_LEN + SPEED);
  localparam logic [10:0]     LEN_M1  = 11'(LASER_LEN - 1);
  localparam logic [9:0]      STEP    = 10'(SPEED);
  localparam logic [9:0]      X_L     = 10'(X_LEFT);
  localparam logic [9:0]      X_R     = 10'(X_LEFT + LASER_W - 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [3:0]      SLOTS_C = 4'(SLOTS);

  // Channel index 0 is the top cannon, 1 is the bottom cannon.
  logic [SLOTS-1:0] act    [2];
  logic [SLOTS-1:0] act_nx [2];
  logic [9:0]       y      [2][SLOTS];
  logic [9:0]       y_nx   [2][SLOTS];
  logic [CD_W-1:0]  cd     [2];
  logic [CD_W-1:0]  cd_nx  [2];
  logic [1:0]       prev;
  logic [1:0]       level;
  logic [1:0]       attempt;
  logic [1:0]       found;

  assign level = {fire_bot, fire_top};

  function automatic logic [3:0] popcount(input logic [SLOTS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < SLOTS; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  always_comb begin
    attempt = '0;
    found   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      act_nx[ch] = act[ch];
      cd_nx[ch]  = cd[ch];
      for (int s = 0; s < SLOTS; s++) y_nx[ch][s] = y[ch][s];

      attempt[ch] = level[ch] & ~prev[ch];
`ifdef LASER_AUTOFIRE_EN
      attempt[ch] = attempt[ch] | (level[ch] & tick & (cd[ch] == '0));
`endif

      if (tick && cd[ch] != '0) cd_nx[ch] = cd[ch] - 1'b1;

      for (int s = 0; s < SLOTS; s++) begin
        if (tick && act[ch][s]) begin
          if (ch == 0) begin
            if (y[ch][s] < T_LIMIT) act_nx[ch][s] = 1'b0;
            else                    y_nx[ch][s]   = y[ch][s] - STEP;
          end else begin
            if ({1'b0, y[ch][s]} + B_REACH > B_LIMIT) act_nx[ch][s] = 1'b0;
            else                                      y_nx[ch][s]   = y[ch][s] + STEP;
          end
        end
      end

      // Slot choice uses pre-movement occupancy, so a bolt retiring this clk still blocks a launch.
      if (attempt[ch] && cd[ch] == '0) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (!act[ch][s] && !found[ch]) begin
            found[ch]      = 1'b1;
            act_nx[ch][s]  = 1'b1;
            y_nx[ch][s]    = (ch == 0) ? T_INIT : B_INIT;
          end
        end
        if (found[ch]) cd_nx[ch] = CD_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        act[ch] <= '0;
        cd[ch]  <= '0;
        for (int s = 0; s < SLOTS; s++) y[ch][s] <= '0;
      end
      prev      <= '0;
      top_count <= '0;
      bot_count <= '0;
      top_full  <= 1'b0;
      bot_full  <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        act[ch] <= act_nx[ch];
        cd[ch]  <= cd_nx[ch];
        for (int s = 0; s < SLOTS; s++) y[ch][s] <= y_nx[ch][s];
      end
      prev      <= level;
      top_count <= popcount(act_nx[0]);
      bot_count <= popcount(act_nx[1]);
      top_full  <= (popcount(act_nx[0]) == SLOTS_C);
      bot_full  <= (popcount(act_nx[1]) == SLOTS_C);
    end
  end

  logic in_col;
  logic hit;

  always_comb begin
    in_col = (hCount >= X_L) && (hCount <= X_R);
    hit    = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (act[ch][s] && vCount >= y[ch][s] &&
            {1'b0, vCount} <= {1'b0, y[ch][s]} + LEN_M1)
          hit = 1'b1;
      end
    end
    laser_fill = bright & in_col & hit;
  end

endmodule

// File: tb/tb_laser_controller.sv
// Directed bench for laser_controller: launch, travel limits, cooldown, full channel, async reset, same-clk events.
module tb_laser_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       fire_top = 1'b0;
  logic       fire_bot = 1'b0;
  logic       bright = 1'b1;
  logic [9:0] hCount = 10'd0;
  logic [9:0] vCount = 10'd0;
  logic       laser_fill;
  logic [3:0] top_count;
  logic [3:0] bot_count;
  logic       top_full;
  logic       bot_full;

  int checks = 0;
  int errors = 0;

  laser_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .fire_top(fire_top), .fire_bot(fire_bot),
    .bright(bright), .hCount(hCount), .vCount(vCount), .laser_fill(laser_fill),
    .top_count(top_count), .bot_count(bot_count), .top_full(top_full), .bot_full(bot_full)
  );

  always #5 clk = ~clk;

  // All stepping starts and ends on a falling edge so outputs are read away from the active edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_top();
    fire_top = 1'b1;
    @(negedge clk);
    fire_top = 1'b0;
    @(negedge clk);
  endtask

  task automatic pix(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    #1;
  endtask

  task automatic check_fill(input string name, input int h, input int v, input logic exp);
    pix(h, v);
    checks++;
    if (laser_fill !== exp) begin
      errors++;
      $display("[TB] FAIL %s fill(%0d,%0d) actual=%b expected=%b", name, h, v, laser_fill, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(2);
    pix(462, 170);
    checks++;
    if ({top_count, bot_count, top_full, bot_full, laser_fill} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs actual=%h/%h/%b/%b/%b expected=0/0/0/0/0",
               top_count, bot_count, top_full, bot_full, laser_fill);
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_top_launch();
    fire_top = 1'b1;
    @(negedge clk);
    fire_top = 1'b0;
    checks++;
    if (top_count !== 4'd1 || bot_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL top_launch_count actual=%0d/%0d expected=1/0", top_count, bot_count);
    end
    check_fill("top_first_row", 462, 163, 1'b1);
    check_fill("top_last_row", 465, 186, 1'b1);
    check_fill("top_above", 462, 162, 1'b0);
    check_fill("top_below", 462, 187, 1'b0);
    check_fill("col_right", 466, 170, 1'b0);
    check_fill("col_left", 461, 170, 1'b0);
    bright = 1'b0;
    check_fill("bright_off", 462, 170, 1'b0);
    bright = 1'b1;
    idle(1);
  endtask

  task automatic test_top_travel();
    ticks(1);
    check_fill("top_tick1_at161", 462, 161, 1'b1);
    check_fill("top_tick1_not160", 462, 160, 1'b0);
    ticks(63);
    check_fill("top_tick64_at35", 462, 35, 1'b1);
    check_fill("top_tick64_end58", 462, 58, 1'b1);
    check_fill("top_tick64_not59", 462, 59, 1'b0);
    checks++;
    if (top_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL top_alive_64 actual=%0d expected=1", top_count);
    end
    ticks(1);
    checks++;
    if (top_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL top_cleared_65 actual=%0d expected=0", top_count);
    end
    check_fill("top_gone", 462, 40, 1'b0);
  endtask

  task automatic test_bot_travel();
    fire_bot = 1'b1;
    @(negedge clk);
    fire_bot = 1'b0;
    checks++;
    if (bot_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL bot_launch_count actual=%0d expected=1", bot_count);
    end
    check_fill("bot_init_365", 462, 365, 1'b1);
    check_fill("bot_init_not364", 462, 364, 1'b0);
    ticks(63);
    check_fill("bot_tick63_at491", 462, 491, 1'b1);
    check_fill("bot_tick63_not490", 462, 490, 1'b0);
    check_fill("bot_tick63_end514", 462, 514, 1'b1);
    check_fill("bot_tick63_not515", 462, 515, 1'b0);
    ticks(1);
    checks++;
    if (bot_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL bot_cleared_64 actual=%0d expected=0", bot_count);
    end
  endtask

  task automatic test_cooldown();
    press_top();
    ticks(5);
    press_top();
    checks++;
    if (top_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL cooldown_5_ignored actual=%0d expected=1", top_count);
    end
    ticks(14);
    press_top();
    checks++;
    if (top_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL cooldown_19_ignored actual=%0d expected=1", top_count);
    end
    ticks(1);
    press_top();
    checks++;
    if (top_count !== 4'd2) begin
      errors++;
      $display("[TB] FAIL cooldown_20_launch actual=%0d expected=2", top_count);
    end
    check_fill("slot1_at163", 462, 163, 1'b1);
    check_fill("slot0_at123", 462, 123, 1'b1);
    check_fill("slot0_not122", 462, 122, 1'b0);
  endtask

  task automatic test_full_and_reset();
    ticks(20);
    press_top();
    checks++;
    if (top_count !== 4'd3 || top_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL top_full_set actual=%0d/%b expected=3/1", top_count, top_full);
    end
    ticks(20);
    press_top();
    checks++;
    if (top_count !== 4'd3 || top_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_fire_dropped actual=%0d/%b expected=3/1", top_count, top_full);
    end
    check_fill("slot0_at43", 462, 43, 1'b1);
    check_fill("slot2_at123", 462, 123, 1'b1);
    rst = 1'b0;
    check_fill("async_reset_fill", 462, 123, 1'b0);
    checks++;
    if (top_count !== 4'd0 || top_full !== 1'b0 || bot_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_counts actual=%0d/%b/%0d expected=0/0/0",
               top_count, top_full, bot_count);
    end
    idle(1);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_back_to_back();
    fire_top = 1'b1;
    fire_bot = 1'b1;
    @(negedge clk);
    fire_top = 1'b0;
    fire_bot = 1'b0;
    checks++;
    if (top_count !== 4'd1 || bot_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL dual_launch actual=%0d/%0d expected=1/1", top_count, bot_count);
    end
    ticks(20);
    fire_top = 1'b1;
    fire_bot = 1'b1;
    tick     = 1'b1;
    @(negedge clk);
    fire_top = 1'b0;
    fire_bot = 1'b0;
    tick     = 1'b0;
    checks++;
    if (top_count !== 4'd2 || bot_count !== 4'd2) begin
      errors++;
      $display("[TB] FAIL same_clk_launch actual=%0d/%0d expected=2/2", top_count, bot_count);
    end
    check_fill("new_top_unmoved", 462, 163, 1'b1);
    check_fill("new_top_not162", 462, 162, 1'b0);
    check_fill("old_top_at121", 462, 121, 1'b1);
    check_fill("old_top_not120", 462, 120, 1'b0);
    check_fill("new_bot_unmoved", 462, 365, 1'b1);
    check_fill("new_bot_not364", 462, 364, 1'b0);
    check_fill("old_bot_at407", 462, 407, 1'b1);
    check_fill("old_bot_not406", 462, 406, 1'b0);
    idle(1);
  endtask

  task automatic test_hold();
    int exp;
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
`ifdef LASER_AUTOFIRE_EN
    exp = 3;
`else
    exp = 1;
`endif
    fire_top = 1'b1;
    @(negedge clk);
    ticks(50);
    fire_top = 1'b0;
    idle(1);
    checks++;
    if (top_count !== 4'(exp)) begin
      errors++;
      $display("[TB] FAIL hold_fire_count actual=%0d expected=%0d", top_count, exp);
    end
  endtask

  initial begin
    test_reset();
    test_top_launch();
    test_top_travel();
    test_bot_travel();
    test_cooldown();
    test_full_and_reset();
    test_back_to_back();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
